// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: default sizes,
// FSM state encoding and a reference pattern.
package seq_pkg;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;
    localparam int GAP_W   = 4;

    localparam logic [3:0] PAT_0110 = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control and serial-output bundle of the pattern transmitter.
// The master side configures and starts transfers; the slave side is the transmitter.
interface seq_pattern_tx_if #(
    parameter int MAX_LEN = seq_pkg::MAX_LEN,
    parameter int LEN_W   = seq_pkg::LEN_W,
    parameter int CNT_W   = seq_pkg::CNT_W,
    parameter int GAP_W   = seq_pkg::GAP_W
);
    logic               start;
    logic               stop;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   pat_len;
    logic [CNT_W-1:0]   rep_cnt;
    logic [GAP_W-1:0]   gap_len;
    logic               data_out;
    logic               data_valid;
    logic               sof;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, stop, pat_in, pat_len, rep_cnt, gap_len,
        input  data_out, data_valid, sof, busy, done, err
    );

    modport slave (
        input  start, stop, pat_in, pat_len, rep_cnt, gap_len,
        output data_out, data_valid, sof, busy, done, err
    );

endinterface

// File: rtl/seq_pattern_tx_down_ctr.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
module seq_down_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first with
// repetition, optional idle gaps, continuous mode and abort.
module seq_pattern_tx #(
    parameter int MAX_LEN = seq_pkg::MAX_LEN,
    parameter int LEN_W   = seq_pkg::LEN_W,
    parameter int CNT_W   = seq_pkg::CNT_W,
    parameter int GAP_W   = seq_pkg::GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    seq_pattern_tx_if.slave  bus
);

    import seq_pkg::*;

    state_t             state;
    logic [MAX_LEN-1:0] pat_sh;
    logic [LEN_W-1:0]   len_sh;
    logic [GAP_W-1:0]   gap_sh;

    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   idx_val;
    logic               idx_zero, idx_load, idx_en;
    logic [CNT_W-1:0]   reps;
    logic               rep_zero, rep_load, rep_en;
    logic [GAP_W-1:0]   gap_cnt;
    logic               gap_zero, gap_load, gap_en;

    logic legal, start_ok, end_rep, final_rep, repeat_now, gap_done, restart;
    logic start_bit, next_bit, first_bit;

    function automatic logic pick_bit(input logic [MAX_LEN-1:0] pat,
                                      input logic [LEN_W-1:0]   pos);
        pick_bit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (pos == LEN_W'(i)) pick_bit = pat[i];
        end
    endfunction

    // A loaded repetition count of zero means continuous mode, so the rep
    // counter is never decremented on the final repetition and cannot wrap.
    always_comb begin
        legal      = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(MAX_LEN));
        start_ok   = (state == IDLE) && bus.start && !bus.stop && legal;
        end_rep    = (state == SEND) && idx_zero && !bus.stop;
        final_rep  = end_rep && !rep_zero && (reps == CNT_W'(1));
        repeat_now = end_rep && !final_rep;
        gap_done   = (state == GAP) && gap_zero && !bus.stop;
        restart    = (repeat_now && (gap_sh == '0)) || gap_done;
        idx_load   = start_ok || restart;
        idx_val    = start_ok ? (bus.pat_len - 1'b1) : (len_sh - 1'b1);
        idx_en     = (state == SEND) && !idx_zero;
        rep_load   = start_ok;
        rep_en     = repeat_now && !rep_zero;
        gap_load   = repeat_now && (gap_sh != '0);
        gap_en     = (state == GAP) && (gap_cnt != '0);
        start_bit  = pick_bit(bus.pat_in, bus.pat_len - 1'b1);
        next_bit   = pick_bit(pat_sh, idx - 1'b1);
        first_bit  = pick_bit(pat_sh, len_sh - 1'b1);
    end

    seq_down_ctr #(.W(LEN_W)) u_idx_ctr (
        .clk(clk), .rst(rst), .load(idx_load), .en(idx_en),
        .load_val(idx_val), .count(idx), .zero(idx_zero)
    );

    seq_down_ctr #(.W(CNT_W)) u_rep_ctr (
        .clk(clk), .rst(rst), .load(rep_load), .en(rep_en),
        .load_val(bus.rep_cnt), .count(reps), .zero(rep_zero)
    );

    // The gap counter is loaded with gap_len-1 so GAP lasts exactly gap_len cycles.
    seq_down_ctr #(.W(GAP_W)) u_gap_ctr (
        .clk(clk), .rst(rst), .load(gap_load), .en(gap_en),
        .load_val(gap_sh - 1'b1), .count(gap_cnt), .zero(gap_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pat_sh         <= '0;
            len_sh         <= '0;
            gap_sh         <= '0;
            bus.data_out   <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.sof        <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.sof  <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state          <= SEND;
                        pat_sh         <= bus.pat_in;
                        len_sh         <= bus.pat_len;
                        gap_sh         <= bus.gap_len;
                        bus.data_out   <= start_bit;
                        bus.data_valid <= 1'b1;
                        bus.sof        <= 1'b1;
                        bus.busy       <= 1'b1;
                    end else if (bus.start && !bus.stop && !legal) begin
                        bus.err <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.stop) begin
                        state          <= IDLE;
                        bus.data_out   <= 1'b0;
                        bus.data_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                    end else if (!idx_zero) begin
                        bus.data_out <= next_bit;
                    end else if (final_rep) begin
                        state          <= IDLE;
                        bus.data_out   <= 1'b0;
                        bus.data_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                    end else if (gap_load) begin
                        state          <= GAP;
                        bus.data_out   <= 1'b0;
                        bus.data_valid <= 1'b0;
                    end else begin
                        bus.data_out <= first_bit;
                        bus.sof      <= 1'b1;
                    end
                end
                GAP: begin
                    if (bus.stop) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (gap_done) begin
                        state          <= SEND;
                        bus.data_out   <= first_bit;
                        bus.data_valid <= 1'b1;
                        bus.sof        <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.data_out   <= 1'b0;
                    bus.data_valid <= 1'b0;
                    bus.busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx.
// Observed vector per cycle is {data_out, data_valid, sof, busy, done, err}.
module tb_seq_pattern_tx;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seq_pattern_tx_if bus ();

    seq_pattern_tx u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [5:0] obs;
    assign obs = {bus.data_out, bus.data_valid, bus.sof, bus.busy, bus.done, bus.err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [7:0] pat, input logic [3:0] len,
                         input logic [7:0] reps, input logic [3:0] gap);
        bus.pat_in  = pat;
        bus.pat_len = len;
        bus.rep_cnt = reps;
        bus.gap_len = gap;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL reset_hold: obs=%b exp=%b", obs, 6'b000000);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("[TB] FAIL reset_idle c%0d: obs=%b exp=%b", i + 1, obs, 6'b000000);
            end
        end
    endtask

    // Pattern 0110 once, then a new start accepted in the done cycle.
    task automatic test_single();
        logic [5:0] exp_a [6];
        logic [5:0] exp_b [4];
        exp_a = '{6'b011100, 6'b110100, 6'b110100, 6'b010100, 6'b000010, 6'b111100};
        exp_b = '{6'b110100, 6'b010100, 6'b000010, 6'b000000};
        setup({4'b0000, seq_pkg::PAT_0110}, 4'd4, 8'd1, 4'd0);
        bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.start = 1'b0;
            checks++;
            if (obs !== exp_a[i]) begin
                errors++;
                $display("[TB] FAIL single c%0d: obs=%b exp=%b", i + 1, obs, exp_a[i]);
            end
            if (i == 4) begin
                setup(8'h06, 4'd3, 8'd1, 4'd0);
                bus.start = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_b[i]) begin
                errors++;
                $display("[TB] FAIL restart_on_done c%0d: obs=%b exp=%b", i + 1, obs, exp_b[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_s [8];
        exp_s = '{6'b111100, 6'b110100, 6'b010100, 6'b111100,
                  6'b110100, 6'b010100, 6'b000010, 6'b000000};
        setup(8'h06, 4'd3, 8'd2, 4'd0);
        bus.start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.start = 1'b0;
            checks++;
            if (obs !== exp_s[i]) begin
                errors++;
                $display("[TB] FAIL back_to_back c%0d: obs=%b exp=%b", i + 1, obs, exp_s[i]);
            end
        end
    endtask

    task automatic test_gap();
        logic [5:0] exp_s [12];
        exp_s = '{6'b011100, 6'b110100, 6'b110100, 6'b010100, 6'b000100, 6'b000100,
                  6'b011100, 6'b110100, 6'b110100, 6'b010100, 6'b000010, 6'b000000};
        setup(8'h06, 4'd4, 8'd2, 4'd2);
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.start = 1'b0;
            checks++;
            if (obs !== exp_s[i]) begin
                errors++;
                $display("[TB] FAIL gap c%0d: obs=%b exp=%b", i + 1, obs, exp_s[i]);
            end
        end
    endtask

    task automatic test_continuous_stop();
        logic [5:0] exp_s [10];
        exp_s = '{6'b111100, 6'b110100, 6'b010100, 6'b111100, 6'b110100,
                  6'b010100, 6'b111100, 6'b110100, 6'b000000, 6'b000000};
        setup(8'h06, 4'd3, 8'd0, 4'd0);
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            checks++;
            if (obs !== exp_s[i]) begin
                errors++;
                $display("[TB] FAIL cont_stop c%0d: obs=%b exp=%b", i + 1, obs, exp_s[i]);
            end
            if (i == 7) bus.stop = 1'b1;
        end
        // Stop beats start in IDLE, even with an illegal length.
        setup(8'h06, 4'd0, 8'd1, 4'd0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL stop_wins: obs=%b exp=%b", obs, 6'b000000);
        end
    endtask

    task automatic test_illegal_and_busy();
        logic [5:0] exp_s [6];
        exp_s = '{6'b011100, 6'b110100, 6'b110100, 6'b010100, 6'b000010, 6'b000000};
        setup(8'h06, 4'd0, 8'd1, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL err_len0: obs=%b exp=%b", obs, 6'b000001);
        end
        tick();
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL err_one_cycle: obs=%b exp=%b", obs, 6'b000000);
        end
        setup(8'h06, 4'd9, 8'd1, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL err_len9: obs=%b exp=%b", obs, 6'b000001);
        end
        setup(8'h06, 4'd4, 8'd1, 4'd0);
        bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.start = 1'b0;
            checks++;
            if (obs !== exp_s[i]) begin
                errors++;
                $display("[TB] FAIL busy_protect c%0d: obs=%b exp=%b", i + 1, obs, exp_s[i]);
            end
            if (i == 0) begin
                setup(8'hF9, 4'd8, 8'd3, 4'd1);
                bus.start = 1'b1;
            end
        end
    endtask

    task automatic test_async_reset();
        setup(8'h06, 4'd4, 8'd1, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (obs !== 6'b110100) begin
            errors++;
            $display("[TB] FAIL areset_pre: obs=%b exp=%b", obs, 6'b110100);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL areset_immediate: obs=%b exp=%b", obs, 6'b000000);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("[TB] FAIL areset_idle c%0d: obs=%b exp=%b", i + 1, obs, 6'b000000);
            end
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (obs !== 6'b011100) begin
            errors++;
            $display("[TB] FAIL areset_restart: obs=%b exp=%b", obs, 6'b011100);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        setup(8'h00, 4'd0, 8'd0, 4'd0);
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_continuous_stop();
        test_illegal_and_busy();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It is the source side of the team's serial sequence-detector path.
- Loads a programmable bit pattern of 1..MAX_LEN bits and shifts it out MSB-first, one bit per clock, with a valid strobe.
- Supports repetition, optional idle gaps between repetitions, a continuous mode and abort.
- Drives stimulus and link traffic into detector blocks; back-to-back repeats exercise overlapping detection.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
LEN_W, 4, width of pat_len and bit index (must hold MAX_LEN)
CNT_W, 8, width of repetition counter
GAP_W, 4, width of inter-repetition gap counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request to begin a transfer; honoured only in IDLE
stop  in  1  abort the current transfer
pat_in  in  MAX_LEN  pattern; bit pat_len-1 is sent first, bit 0 last
pat_len  in  LEN_W  pattern length; legal range 1..MAX_LEN
rep_cnt  in  CNT_W  number of repetitions; 0 = continuous until stop
gap_len  in  GAP_W  idle cycles inserted between repetitions
data_out  out  1  serial bit
data_valid  out  1  data_out carries a pattern bit
sof  out  1  high with the first bit of every repetition
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after the final bit
err  out  1  one-cycle pulse when a start is rejected for an illegal length

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; data_out, data_valid, sof, busy, done and err all 0; counters and shadow registers cleared. Reset mid-transfer takes effect immediately, with no partial bits or done afterwards.
- All outputs are registered.
- State machine: IDLE, SEND, GAP.
- IDLE:
  - start=1 with legal pat_len: latch pat_in, pat_len, rep_cnt and gap_len into shadow registers, then go to SEND. At that same edge, drive data_out=pat_in[pat_len-1], data_valid=1, sof=1, busy=1. Latency is one cycle from the start edge.
  - start=1 with pat_len=0 or pat_len>MAX_LEN: stay in IDLE and pulse err for one cycle.
- SEND:
  - One bit per cycle; the bit index counts down to 0.
  - Input changes are ignored, because shadow registers are used. start is ignored while busy.
- End of a repetition (index 0 has just been driven):
  - If repetitions remain (or continuous mode) and gap=0: the next cycle carries the first bit again with sof=1, giving contiguous valid bits.
  - If repetitions remain and gap>0: enter GAP for exactly gap_len cycles with data_valid=0, data_out=0, busy=1. Then SEND restarts with sof=1.
  - If this was the final repetition: return to IDLE. The next cycle has data_valid=0, busy=0, done=1 for one cycle. A start in that cycle is accepted.
- Repetition counter: loads rep_cnt and decrements once per completed repetition. It never wraps. In continuous mode (rep_cnt=0) it does not decrement.
- stop=1 while busy (in SEND or GAP): at that edge go to IDLE. The next cycle has data_valid=0, sof=0, busy=0. done is not pulsed.
- stop=1 and start=1 together in IDLE: stop wins, start is dropped, err=0.
- sof is 0 for every bit except the first of each repetition.
- data_out=0 whenever data_valid=0.

Decomposition:
- Shared package seq_pkg holds:
  - state encoding constants: IDLE=2'd0, SEND=2'd1, GAP=2'd2
  - MAX_LEN default
  - default pattern constant PAT_0110=4'b0110
- One sub-module, seq_down_ctr: a loadable down-counter with load, enable and zero flag, parameterised by width. It is instantiated for the bit index, the repetition count and the gap count.

Test Plan:
- Single pattern: pat_in=8'h06, pat_len=4, rep_cnt=1, gap_len=0, start pulse → data_out 0,1,1,0 on 4 consecutive valid cycles; sof only on the first; busy for 4 cycles; done=1 on cycle 5.
- Contiguous repeat: pat_in=8'h06, pat_len=3, rep_cnt=2, gap_len=0 → 1,1,0,1,1,0 with no valid gap; sof on bits 1 and 4; a single done afterwards.
- Gap insertion: pat_in=8'h06, pat_len=4, rep_cnt=2, gap_len=2 → 0110, then 2 cycles of data_valid=0, then 0110; busy stays high throughout the gap.
- Continuous and stop: rep_cnt=0, pat_len=3, stop asserted on the 2nd bit of the 3rd repetition → data_valid=0 and busy=0 next cycle; done never pulses.
- Illegal length and busy protection: pat_len=0 with start → err pulses for one cycle and busy=0. Then start a legal transfer, and mid-transfer change pat_in and pulse start → the original pattern completes unchanged.
- Async reset: drive rst=0 between clock edges during SEND → all outputs 0 before the next edge. After release, behaviour is idle until a new start.
